// File: rtl/fsm_updown.sv
// Bidirectional WIDTH-bit sequencing counter: reversal dwell, wrap/saturate, load, terminal flags.
// Define FSM_GRAY_OUT_EN to present y as the Gray code of the internal binary count.
module fsm_updown #(
    parameter int unsigned      WIDTH    = 2,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter bit               SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up,
    input  logic             down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] y,
    output logic             at_max,
    output logic             at_min,
    output logic             wrap
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] y_q;
    logic             wrap_q;

    logic             up_req;
    logic             dn_req;
    logic [WIDTH-1:0] inc_d;
    logic [WIDTH-1:0] dec_d;
    logic [WIDTH-1:0] load_d;
    logic             inc_wrap;
    logic             dec_wrap;

    function automatic logic [WIDTH-1:0] encode(input logic [WIDTH-1:0] c);
`ifdef FSM_GRAY_OUT_EN
        return c ^ (c >> 1);
`else
        return c;
`endif
    endfunction

    // Request decode and the candidate next counts; range is 0..MAX_VAL, not 0..2**WIDTH-1.
    always_comb begin
        up_req   = up & ~down;
        dn_req   = down & ~up;
        inc_d    = count_q + WIDTH'(1);
        inc_wrap = 1'b0;
        dec_d    = count_q - WIDTH'(1);
        dec_wrap = 1'b0;
        if (count_q == MAX_VAL) begin
            inc_d    = SATURATE ? MAX_VAL : '0;
            inc_wrap = !SATURATE;
        end
        if (count_q == '0) begin
            dec_d    = SATURATE ? '0 : MAX_VAL;
            dec_wrap = !SATURATE;
        end
        load_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end

    // Direction FSM; a request against the current direction dwells one edge in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            y_q     <= '0;
            wrap_q  <= 1'b0;
        end else if (load) begin
            state_q <= ST_IDLE;
            count_q <= load_d;
            y_q     <= encode(load_d);
            wrap_q  <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (up_req) begin
                        state_q <= ST_UP;
                        count_q <= inc_d;
                        y_q     <= encode(inc_d);
                        wrap_q  <= inc_wrap;
                    end else if (dn_req) begin
                        state_q <= ST_DOWN;
                        count_q <= dec_d;
                        y_q     <= encode(dec_d);
                        wrap_q  <= dec_wrap;
                    end
                end
                ST_UP: begin
                    if (up_req) begin
                        count_q <= inc_d;
                        y_q     <= encode(inc_d);
                        wrap_q  <= inc_wrap;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_DOWN: begin
                    if (dn_req) begin
                        count_q <= dec_d;
                        y_q     <= encode(dec_d);
                        wrap_q  <= dec_wrap;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign y      = y_q;
    assign wrap   = wrap_q;
    assign at_max = (count_q == MAX_VAL);
    assign at_min = (count_q == '0);

endmodule

// File: tb/tb_fsm_updown.sv
// Scoreboard bench for fsm_updown over three configurations (default, saturating 3-bit, MAX_VAL=2).
module tb_fsm_updown;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0 = 1'b1, up0 = 1'b0, dn0 = 1'b0, ld0 = 1'b0;
    logic       rst1 = 1'b1, up1 = 1'b0, dn1 = 1'b0, ld1 = 1'b0;
    logic       rst2 = 1'b1, up2 = 1'b0, dn2 = 1'b0, ld2 = 1'b0;
    logic [1:0] lv0 = '0, lv2 = '0;
    logic [2:0] lv1 = '0;
    logic [1:0] y0, y2;
    logic [2:0] y1;
    logic       mx0, mn0, wr0, mx1, mn1, wr1, mx2, mn2, wr2;

    fsm_updown u_dut0 (
        .clk(clk), .rst(rst0), .up(up0), .down(dn0), .load(ld0), .load_val(lv0),
        .y(y0), .at_max(mx0), .at_min(mn0), .wrap(wr0)
    );

    fsm_updown #(.WIDTH(3), .MAX_VAL(3'd5), .SATURATE(1'b1)) u_dut1 (
        .clk(clk), .rst(rst1), .up(up1), .down(dn1), .load(ld1), .load_val(lv1),
        .y(y1), .at_max(mx1), .at_min(mn1), .wrap(wr1)
    );

    fsm_updown #(.WIDTH(2), .MAX_VAL(2'd2), .SATURATE(1'b0)) u_dut2 (
        .clk(clk), .rst(rst2), .up(up2), .down(dn2), .load(ld2), .load_val(lv2),
        .y(y2), .at_max(mx2), .at_min(mn2), .wrap(wr2)
    );

    typedef struct {
        int       id;
        logic [2:0] y;
        logic     mx;
        logic     mn;
        logic     wr;
        string    nm;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [2:0] enc(input logic [2:0] c);
`ifdef FSM_GRAY_OUT_EN
        return c ^ (c >> 1);
`else
        return c;
`endif
    endfunction

    // Drive one edge of stimulus to one instance and queue its expected response.
    task automatic step(input int id, input logic r, input logic u, input logic d,
                        input logic l, input logic [2:0] lv, input logic [2:0] ey,
                        input logic emx, input logic emn, input logic ewr, input string nm);
        exp_t e;
        @(posedge clk);
        #2;
        case (id)
            0: begin rst0 = r; up0 = u; dn0 = d; ld0 = l; lv0 = lv[1:0]; end
            1: begin rst1 = r; up1 = u; dn1 = d; ld1 = l; lv1 = lv; end
            default: begin rst2 = r; up2 = u; dn2 = d; ld2 = l; lv2 = lv[1:0]; end
        endcase
        e.id = id; e.y = enc(ey); e.mx = emx; e.mn = emn; e.wr = ewr; e.nm = nm;
        q.push_back(e);
    endtask

    // Monitor: every edge with a pending expectation, compare the addressed instance.
    exp_t       m_e;
    logic [2:0] a_y;
    logic       a_mx, a_mn, a_wr;
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            m_e = q.pop_front();
            case (m_e.id)
                0: begin a_y = {1'b0, y0}; a_mx = mx0; a_mn = mn0; a_wr = wr0; end
                1: begin a_y = y1; a_mx = mx1; a_mn = mn1; a_wr = wr1; end
                default: begin a_y = {1'b0, y2}; a_mx = mx2; a_mn = mn2; a_wr = wr2; end
            endcase
            total++;
            if (a_y !== m_e.y || a_mx !== m_e.mx || a_mn !== m_e.mn || a_wr !== m_e.wr) begin
                bad++;
                $display("FAIL %s dut%0d: got y=%0h max=%b min=%b wrap=%b, want y=%0h max=%b min=%b wrap=%b",
                         m_e.nm, m_e.id, a_y, a_mx, a_mn, a_wr, m_e.y, m_e.mx, m_e.mn, m_e.wr);
            end
        end
    end

    initial begin
        // Default config: wrap at 3, then reversal dwell and wrap downward.
        step(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, "d0_reset");
        step(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, "d0_up1");
        step(0, 0, 1, 0, 0, 0, 2, 0, 0, 0, "d0_up2");
        step(0, 0, 1, 0, 0, 0, 3, 1, 0, 0, "d0_up3");
        step(0, 0, 1, 0, 0, 0, 0, 0, 1, 1, "d0_upwrap");
        step(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, "d0_up5");
        step(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, "d0_dwell");
        step(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, "d0_dn0");
        step(0, 0, 0, 1, 0, 0, 3, 1, 0, 1, "d0_dnwrap");
        // Reset mid-count overrides a held up request.
        step(0, 1, 1, 0, 0, 0, 0, 0, 1, 0, "d0_reset2");
        step(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, "d0_r_up1");
        step(0, 0, 1, 0, 0, 0, 2, 0, 0, 0, "d0_r_up2");
        step(0, 1, 1, 0, 0, 0, 0, 0, 1, 0, "d0_midrst");
        step(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, "d0_afterrst");

        // Saturating 3-bit, MAX_VAL=5.
        step(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, "d1_reset");
        step(1, 0, 1, 0, 0, 0, 1, 0, 0, 0, "d1_up1");
        step(1, 0, 1, 0, 0, 0, 2, 0, 0, 0, "d1_up2");
        step(1, 0, 1, 0, 0, 0, 3, 0, 0, 0, "d1_up3");
        step(1, 0, 1, 0, 0, 0, 4, 0, 0, 0, "d1_up4");
        step(1, 0, 1, 0, 0, 0, 5, 1, 0, 0, "d1_up5");
        step(1, 0, 1, 0, 0, 0, 5, 1, 0, 0, "d1_sat_hi1");
        step(1, 0, 1, 0, 0, 0, 5, 1, 0, 0, "d1_sat_hi2");
        step(1, 0, 0, 1, 0, 0, 5, 1, 0, 0, "d1_dwell");
        step(1, 0, 0, 1, 0, 0, 4, 0, 0, 0, "d1_dn4");
        step(1, 0, 0, 1, 0, 0, 3, 0, 0, 0, "d1_dn3");
        step(1, 0, 0, 1, 0, 0, 2, 0, 0, 0, "d1_dn2");
        step(1, 0, 0, 1, 0, 0, 1, 0, 0, 0, "d1_dn1");
        step(1, 0, 0, 1, 0, 0, 0, 0, 1, 0, "d1_dn0");
        step(1, 0, 0, 1, 0, 0, 0, 0, 1, 0, "d1_sat_lo");

        // MAX_VAL=2: load clamp, no dwell after load, both-request hold, modulo-3 wrap.
        step(2, 1, 0, 0, 0, 0, 0, 0, 1, 0, "d2_reset");
        step(2, 0, 0, 0, 1, 3, 2, 1, 0, 0, "d2_load_clamp");
        step(2, 0, 0, 1, 0, 0, 1, 0, 0, 0, "d2_dn_nodwell");
        step(2, 0, 1, 1, 0, 0, 1, 0, 0, 0, "d2_both_hold");
        step(2, 0, 1, 0, 0, 0, 2, 1, 0, 0, "d2_up2");
        step(2, 0, 1, 0, 0, 0, 0, 0, 1, 1, "d2_mod3_wrap");
        step(2, 0, 0, 1, 0, 0, 0, 0, 1, 0, "d2_dwell");
        step(2, 0, 0, 1, 0, 0, 2, 1, 0, 1, "d2_dnwrap");
        step(2, 0, 1, 0, 1, 1, 1, 0, 0, 0, "d2_load_over_up");
        step(2, 0, 1, 0, 0, 0, 2, 1, 0, 0, "d2_up_after_load");

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #3;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
